fetch_pc_unit: RTL and testbench

Program-counter and fetch-control stage that sits directly upstream of the combinational instruction memory in the single-cycle MIPS datapath. It holds the PC, drives the word address into instruction memory, receives the fetched word the same cycle, and computes the next PC from sequential, branch, jump and jump-register requests. It also enforces stall, halt-on-sentinel and out-of-range/misaligned fault handling, and keeps a fetch counter.

---
 rtl/fetch_pc_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Program counter and fetch control for the single-cycle MIPS datapath. The PC
// addresses a combinational instruction memory, and the returned word comes
// back in the same cycle. The next PC is chosen from the sequential, branch,
// jump and jump-register targets. The unit stops on a halt sentinel, faults on
// a misaligned or out-of-range next PC, and counts PC updates.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          hold PC and drop any redirect this cycle
//   branch_taken   take PC-relative branch (branch_offset in words)
//   branch_offset  sign-extended 16-bit immediate
//   jump           J/JAL absolute jump using jump_index
//   jump_index     instr[25:0] of the jump
//   jump_reg       JR/JALR jump to jump_reg_addr
//   jump_reg_addr  register target
//   imem_instr     instruction word for imem_addr
//   imem_addr      current PC (combinational)
//   pc_plus4       PC + 4 (combinational)
//   instr          imem_instr while running, otherwise NOP
//   instr_valid    high in RUN
//   halted         high in HALT
//   fault          high in FAULT
//   fault_addr     rejected next PC, captured on fault entry
//   fetch_count    saturating count of PC updates since reset
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] fault_addr_next;
    logic [31:0] count_next;

    logic [31:0] seq_target;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        target_bad;

    // Candidate targets. All arithmetic wraps modulo 2^32.
    assign seq_target = pc + 32'd4;
    assign br_target  = seq_target + {branch_offset[29:0], 2'b00};
    assign j_target   = {seq_target[31:28], jump_index, 2'b00};

    // Redirect priority: jump_reg > jump > branch > sequential.
    always_comb begin
        if (jump_reg)
            target = jump_reg_addr;
        else if (jump)
            target = j_target;
        else if (branch_taken)
            target = br_target;
        else
            target = seq_target;
    end

    // The fault check looks only at the selected candidate. It never feeds
    // back into the selection, so the PC path has no combinational loop.
    assign target_bad = (target[1:0] != 2'b00) || (target >= IMEM_LIMIT);

    always_comb begin
        // NOTE: every variable gets a default before any branch. Otherwise a
        // path that leaves one unassigned would infer a latch.
        state_next      = state;
        pc_next         = pc;
        fault_addr_next = fault_addr;
        count_next      = fetch_count;

        if (state == ST_RUN && !stall) begin
            if (imem_instr == HALT_WORD) begin
                state_next = ST_HALT;
            end else if (target_bad) begin
                state_next      = ST_FAULT;
                fault_addr_next = target;
            end else begin
                pc_next = target;
                if (fetch_count != 32'hFFFF_FFFF)
                    count_next = fetch_count + 32'd1;
            end
        end
        // HALT and FAULT are absorbing: the defaults keep everything frozen.
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            fault_addr  <= 32'h0000_0000;
            fetch_count <= 32'h0000_0000;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fault_addr  <= fault_addr_next;
            fetch_count <= count_next;
        end
    end

    assign imem_addr   = pc;
    assign pc_plus4    = seq_target;
    assign instr_valid = (state == ST_RUN);
    assign halted      = (state == ST_HALT);
    assign fault       = (state == ST_FAULT);
    assign instr       = instr_valid ? imem_instr : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Table-driven directed test for fetch_pc_unit. Each record holds the inputs
// for one clock edge and the hand-computed state expected after that edge. A
// hand-written sequence then runs up to a halt sentinel, waiting a bounded
// number of cycles.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI = 32'h2008_0001;
    localparam logic [1:0]  RUN  = 2'd0;
    localparam logic [1:0]  HLT  = 2'd1;
    localparam logic [1:0]  FLT  = 2'd2;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jra;
        logic [31:0] imem;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic [1:0]  exp_st;
        logic [31:0] exp_fa;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jump_reg = 1'b0;
    logic [31:0] jump_reg_addr = '0;
    logic [31:0] imem_instr = '0;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    fetch_pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jump_reg_addr (jump_reg_addr),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .pc_plus4      (pc_plus4),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .fault         (fault),
        .fault_addr    (fault_addr),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic stl,
        input logic br, input logic [31:0] off,
        input logic jmp, input logic [25:0] idx,
        input logic jr, input logic [31:0] jra,
        input logic [31:0] imem,
        input logic [31:0] exp_pc, input logic [31:0] exp_cnt,
        input logic [1:0] exp_st, input logic [31:0] exp_fa);
        vec_t v;
        v.rst = rst;   v.stl = stl;
        v.br  = br;    v.off = off;
        v.jmp = jmp;   v.idx = idx;
        v.jr  = jr;    v.jra = jra;
        v.imem = imem;
        v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
        v.exp_st = exp_st; v.exp_fa  = exp_fa;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset         = v.rst;
        stall         = v.stl;
        branch_taken  = v.br;
        branch_offset = v.off;
        jump          = v.jmp;
        jump_index    = v.idx;
        jump_reg      = v.jr;
        jump_reg_addr = v.jra;
        imem_instr    = v.imem;
    endtask

    initial begin
        logic [1:0] prev_st;
        int         cycles;
        bit         seen;

        //           rst stl br off           jmp idx     jr jra          imem  pc        cnt  st   fa
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h000, 0, RUN, 32'h0));
        vecs.push_back(mk(1, 0, 1, 32'h10,       1, 26'h40, 1, 32'h80,    ADDI, 32'h000, 0, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h004, 1, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h008, 2, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h00C, 3, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h010, 4, RUN, 32'h0));
        // jump beats branch
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 1, 26'h40, 0, 32'h0,     ADDI, 32'h100, 5, RUN, 32'h0));
        // backward branch: 0x104 - 8
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 0, 26'h0,  0, 32'h0,     ADDI, 32'h0FC, 6, RUN, 32'h0));
        // jump_reg beats everything
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 1, 26'h40, 1, 32'h80,    ADDI, 32'h080, 7, RUN, 32'h0));
        // misaligned jump_reg target faults
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 1, 26'h40, 1, 32'h82,    ADDI, 32'h080, 7, FLT, 32'h82));
        // FAULT absorbs everything, including a halt word
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 26'h40, 0, 32'h0,     HALT, 32'h080, 7, FLT, 32'h82));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h000, 0, RUN, 32'h0));
        // last legal word, then sequential step out of range
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  1, 32'h3FC,   ADDI, 32'h3FC, 1, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h3FC, 1, FLT, 32'h400));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 26'h0,  1, 32'h80,    ADDI, 32'h000, 0, RUN, 32'h0));
        // stall with a jump present only during the stall
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  1, 32'h8,     ADDI, 32'h008, 1, RUN, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 26'h40, 0, 32'h0,     ADDI, 32'h008, 1, RUN, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 26'h40, 0, 32'h0,     ADDI, 32'h008, 1, RUN, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 26'h40, 0, 32'h0,     ADDI, 32'h008, 1, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h00C, 2, RUN, 32'h0));
        // halt word at 0x14
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  1, 32'h14,    ADDI, 32'h014, 3, RUN, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     HALT, 32'h014, 3, HLT, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h4,        1, 26'h40, 0, 32'h0,     ADDI, 32'h014, 3, HLT, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 26'h0,  1, 32'h0,     HALT, 32'h014, 3, HLT, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h000, 0, RUN, 32'h0));
        // stall outranks halt detection
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 26'h0,  0, 32'h0,     HALT, 32'h000, 0, RUN, 32'h0));
        // branch offset -1 word: 0 + 4 - 4
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 0, 26'h0,  0, 32'h0,     ADDI, 32'h000, 1, RUN, 32'h0));
        // branch wraps below zero -> out of range
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 0, 26'h0,  0, 32'h0,     ADDI, 32'h000, 1, FLT, 32'hFFFFFFFC));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,     ADDI, 32'h000, 0, RUN, 32'h0));

        prev_st = RUN;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v);
            #1;
            // Same-cycle view: the fetched word passes through only in RUN.
            if (i > 0) begin
                check($sformatf("v%0d pre instr", i), instr,
                      (prev_st == RUN) ? v.imem : 32'h0);
                check($sformatf("v%0d pre instr_valid", i), {31'b0, instr_valid},
                      {31'b0, prev_st == RUN});
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d imem_addr", i),   imem_addr,   v.exp_pc);
            check($sformatf("v%0d pc_plus4", i),    pc_plus4,    v.exp_pc + 32'd4);
            check($sformatf("v%0d fetch_count", i), fetch_count, v.exp_cnt);
            check($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, v.exp_st == RUN});
            check($sformatf("v%0d halted", i),      {31'b0, halted},      {31'b0, v.exp_st == HLT});
            check($sformatf("v%0d fault", i),       {31'b0, fault},       {31'b0, v.exp_st == FLT});
            check($sformatf("v%0d fault_addr", i),  fault_addr,  v.exp_fa);
            check($sformatf("v%0d instr", i),       instr,       (v.exp_st == RUN) ? v.imem : 32'h0);
            prev_st = v.exp_st;
        end

        // Hand-written sequence: run straight from reset until a halt word
        // placed at 0x20 stops the fetch. Eight updates, then the halt edge.
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            imem_instr = (imem_addr == 32'h20) ? HALT : ADDI;
            @(posedge clk);
            #1;
            cycles++;
            if (halted) seen = 1'b1;
        end
        check("seq halted within budget", {31'b0, halted}, 32'd1);
        check("seq cycles to halt",       32'(cycles),     32'd9);
        check("seq fetch_count",          fetch_count,     32'd8);
        check("seq halt pc",              imem_addr,       32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
